tone_sequencer: RTL and testbench

//  Plays a stored sequence of notes on the 8-tone frequency generator.

---
 rtl/tone_sequencer_if.sv | 38 +++
 rtl/tone_sequencer.sv | 172 +++++++++++++++++
 tb/tb_tone_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_sequencer_if.sv
// Control, program-load and tone-generator signals of tone_sequencer.
//   master : user controls / program loader side (drives start, stop, loop_en, wr_*)
//   slave  : the sequencer itself (drives note_sel, gen_rst, tone_en, busy, done, cur_idx)
// Signals:
//   start, stop, loop_en : play control
//   wr_en, wr_addr, wr_note[3:0] ({rest, note[2:0]}), wr_dur[7:0] : program write port
//   note_sel[2:0], gen_rst : to the 8-tone generator
//   tone_en, busy, done, cur_idx : status
interface tone_sequencer_if #(
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              start;
  logic              stop;
  logic              loop_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_note;
  logic [7:0]        wr_dur;

  logic [2:0]        note_sel;
  logic              gen_rst;
  logic              tone_en;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cur_idx;

  modport master (
    output start, stop, loop_en, wr_en, wr_addr, wr_note, wr_dur,
    input  note_sel, gen_rst, tone_en, busy, done, cur_idx
  );

  modport slave (
    input  start, stop, loop_en, wr_en, wr_addr, wr_note, wr_dur,
    output note_sel, gen_rst, tone_en, busy, done, cur_idx
  );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a stored note sequence on the 8-tone frequency generator.
// Each program entry is {rest, note[2:0], dur[7:0]}; dur counts units of
// TICK_DIV clocks, dur==0 marks end of sequence. Every note is followed by
// GAP_UNITS silent units (generator held in reset).
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : tone_sequencer_if.slave (controls, program write port, generator/status outputs)
module tone_sequencer #(
  parameter int DEPTH     = 16,
  parameter int TICK_DIV  = 5_000_000,
  parameter int GAP_UNITS = 1
) (
  input logic              clk,
  input logic              reset_n,
  tone_sequencer_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state;
  logic [2:0]        note_sel;
  logic              gen_rst;
  logic              tone_en;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cur_idx;
  logic [TICK_W-1:0] tick;
  logic [7:0]        rem;

  logic [11:0]       mem [DEPTH];
  logic [11:0]       rd_word;
  logic [3:0]        rd_note;
  logic [7:0]        rd_dur;

  logic              unit_end;
  state_t            adv_state;
  logic [ADDR_W-1:0] adv_idx;

  assign bus.note_sel = note_sel;
  assign bus.gen_rst  = gen_rst;
  assign bus.tone_en  = tone_en;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.cur_idx  = cur_idx;

  // Program store: not reset, writable only while not playing.
  always_ff @(posedge clk) begin
    if (bus.wr_en && (state == S_IDLE || state == S_DONE))
      mem[bus.wr_addr] <= {bus.wr_note, bus.wr_dur};
  end

  assign rd_word = mem[cur_idx];
  assign rd_note = rd_word[11:8];
  assign rd_dur  = rd_word[7:0];

  assign unit_end = (tick == TICK_W'(TICK_DIV - 1));

  // Step to the next entry after a note (and its gap); the last entry either
  // wraps to 0 or finishes, depending on loop_en at this moment.
  always_comb begin
    adv_state = S_LOAD;
    adv_idx   = cur_idx + ADDR_W'(1);
    if (cur_idx == ADDR_W'(DEPTH - 1)) begin
      if (bus.loop_en) begin
        adv_idx = '0;
      end else begin
        adv_state = S_DONE;
        adv_idx   = cur_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      note_sel <= '0;
      gen_rst  <= 1'b1;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_idx  <= '0;
      tick     <= '0;
      rem      <= '0;
    end else begin
      done <= 1'b0;
      if (bus.stop) begin
        state   <= S_IDLE;
        tone_en <= 1'b0;
        gen_rst <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            gen_rst <= 1'b1;
            tone_en <= 1'b0;
            if (bus.start) begin
              cur_idx <= '0;
              busy    <= 1'b1;
              state   <= S_LOAD;
            end
          end

          S_LOAD: begin
            if (rd_dur != 8'd0) begin
              note_sel <= rd_note[2:0];
              tone_en  <= ~rd_note[3];
              gen_rst  <= 1'b0;
              tick     <= '0;
              rem      <= rd_dur;
              state    <= S_PLAY;
            end else if (cur_idx != '0 && bus.loop_en) begin
              cur_idx <= '0;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end

          // PLAY and GAP share the unit counter; rem counts down the units
          // left, so the final unit ends when rem==1 at a wrap.
          S_PLAY, S_GAP: begin
            if (!unit_end) begin
              tick <= tick + TICK_W'(1);
            end else begin
              tick <= '0;
              if (rem != 8'd1) begin
                rem <= rem - 8'd1;
              end else if (state == S_PLAY && GAP_UNITS > 0) begin
                rem     <= 8'(GAP_UNITS);
                tone_en <= 1'b0;
                gen_rst <= 1'b1;
                state   <= S_GAP;
              end else begin
                tone_en <= 1'b0;
                gen_rst <= 1'b1;
                cur_idx <= adv_idx;
                state   <= adv_state;
                if (adv_state == S_DONE) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                end
              end
            end
          end

          S_DONE: begin
            state <= S_IDLE;
          end

          default: begin
            state   <= S_IDLE;
            tone_en <= 1'b0;
            gen_rst <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer (DEPTH=4, TICK_DIV=4, GAP_UNITS=1).
// Outputs are tracked as runs of constant value {note_sel, gen_rst, tone_en,
// busy, done, cur_idx}; stimulus queues the expected runs, the monitor
// compares each run (value and length) when it ends.
module tb_tone_sequencer;

  logic clk;
  logic reset_n;

  tone_sequencer_if #(.DEPTH(4)) bus ();

  tone_sequencer #(
    .DEPTH(4),
    .TICK_DIV(4),
    .GAP_UNITS(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] val;
    int         len;   // 0 = any length
  } seg_t;

  seg_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;
  bit   flush    = 1'b0;
  bit   have     = 1'b0;
  logic [8:0] seg_val;
  int   seg_len;
  int   seg_no   = 0;

  function automatic logic [8:0] pack(input logic [2:0] n, input logic gr, input logic te,
                                      input logic b, input logic d, input logic [1:0] idx);
    return {n, gr, te, b, d, idx};
  endfunction

  task automatic expect_seg(input logic [2:0] n, input logic gr, input logic te,
                            input logic b, input logic d, input logic [1:0] idx, input int len);
    seg_t s;
    s.val = pack(n, gr, te, b, d, idx);
    s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic check_seg(input logic [8:0] v, input int len);
    seg_t e;
    n_checks++;
    seg_no++;
    if (exp_q.size() == 0) begin
      $display("FAIL seg%0d: unexpected run note/gr/te/busy/done/idx=%h len=%0d, none required",
               seg_no, v, len);
    end else begin
      e = exp_q.pop_front();
      if (v !== e.val || (e.len != 0 && len != e.len))
        $display("FAIL seg%0d: got run %h len=%0d, required %h len=%0d",
                 seg_no, v, len, e.val, e.len);
      else
        n_pass++;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got %0d, required %0d", name, act, req);
    else n_pass++;
  endtask

  // Monitor: run-length encode the outputs and score each completed run.
  always @(negedge clk) begin
    logic [8:0] cur;
    if (mon_en) begin
      cur = pack(bus.note_sel, bus.gen_rst, bus.tone_en, bus.busy, bus.done, bus.cur_idx);
      if (have && cur === seg_val) begin
        seg_len++;
      end else begin
        if (have) check_seg(seg_val, seg_len);
        seg_val = cur;
        seg_len = 1;
        have    = 1'b1;
      end
      if (flush) begin
        check_seg(seg_val, seg_len);
        have = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] note, input logic [7:0] dur);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_note = note;
    bus.wr_dur  = dur;
    cyc(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.loop_en = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_note = '0;
    bus.wr_dur  = '0;
    cyc(3);
    chk("rst_note_sel", int'(bus.note_sel), 0);
    chk("rst_gen_rst",  int'(bus.gen_rst), 1);
    chk("rst_tone_en",  int'(bus.tone_en), 0);
    chk("rst_busy",     int'(bus.busy), 0);
    chk("rst_done",     int'(bus.done), 0);
    chk("rst_cur_idx",  int'(bus.cur_idx), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    expect_seg(0, 1, 0, 0, 0, 0, 0);

    // 1: two notes then end marker
    wr(0, 4'd3, 8'd2);
    wr(1, 4'd5, 8'd1);
    wr(2, 4'd0, 8'd0);
    expect_seg(0, 1, 0, 1, 0, 0, 1);
    expect_seg(3, 0, 1, 1, 0, 0, 8);
    expect_seg(3, 1, 0, 1, 0, 0, 4);
    expect_seg(3, 1, 0, 1, 0, 1, 1);
    expect_seg(5, 0, 1, 1, 0, 1, 4);
    expect_seg(5, 1, 0, 1, 0, 1, 4);
    expect_seg(5, 1, 0, 1, 0, 2, 1);
    expect_seg(5, 1, 0, 0, 1, 2, 1);
    expect_seg(5, 1, 0, 0, 0, 2, 0);
    start_pulse();
    cyc(30);

    // 2: empty program at entry 0 finishes even with loop_en
    bus.loop_en = 1'b1;
    wr(0, 4'd0, 8'd0);
    expect_seg(5, 1, 0, 1, 0, 0, 1);
    expect_seg(5, 1, 0, 0, 1, 0, 1);
    expect_seg(5, 1, 0, 0, 0, 0, 0);
    start_pulse();
    cyc(6);

    // 3: full-depth loop, two laps, loop_en cleared during idx 2 of lap 2
    for (int i = 0; i < 4; i++) wr(2'(i), 4'(i + 1), 8'd1);
    expect_seg(5, 1, 0, 1, 0, 0, 1);
    for (int lap = 0; lap < 2; lap++) begin
      for (int i = 0; i < 4; i++) begin
        expect_seg(3'(i + 1), 0, 1, 1, 0, 2'(i), 4);
        expect_seg(3'(i + 1), 1, 0, 1, 0, 2'(i), 4);
        if (!(lap == 1 && i == 3))
          expect_seg(3'(i + 1), 1, 0, 1, 0, 2'((i + 1) % 4), 1);
      end
    end
    expect_seg(4, 1, 0, 0, 1, 3, 1);
    expect_seg(4, 1, 0, 0, 0, 3, 0);
    start_pulse();
    cyc(56);
    bus.loop_en = 1'b0;
    cyc(30);

    // 4: rest entry keeps generator running but audio gated
    wr(0, 4'd8, 8'd2);
    wr(1, 4'd0, 8'd0);
    expect_seg(4, 1, 0, 1, 0, 0, 1);
    expect_seg(0, 0, 0, 1, 0, 0, 8);
    expect_seg(0, 1, 0, 1, 0, 0, 4);
    expect_seg(0, 1, 0, 1, 0, 1, 1);
    expect_seg(0, 1, 0, 0, 1, 1, 1);
    expect_seg(0, 1, 0, 0, 0, 1, 0);
    start_pulse();
    cyc(20);

    // 5: stop 3 cycles into PLAY; write during PLAY must be dropped
    wr(0, 4'd2, 8'd3);
    expect_seg(0, 1, 0, 1, 0, 0, 1);
    expect_seg(2, 0, 1, 1, 0, 0, 3);
    expect_seg(2, 1, 0, 0, 0, 0, 0);
    start_pulse();
    cyc(1);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'd0;
    bus.wr_note = 4'd7;
    bus.wr_dur  = 8'd5;
    cyc(1);
    bus.wr_en = 1'b0;
    cyc(1);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    cyc(3);
    expect_seg(2, 1, 0, 1, 0, 0, 1);
    expect_seg(2, 0, 1, 1, 0, 0, 12);
    expect_seg(2, 1, 0, 1, 0, 0, 4);
    expect_seg(2, 1, 0, 1, 0, 1, 1);
    expect_seg(2, 1, 0, 0, 1, 1, 1);
    expect_seg(2, 1, 0, 0, 0, 1, 0);
    start_pulse();
    cyc(25);

    // 6: asynchronous reset mid-PLAY, then replay from entry 0
    wr(0, 4'd6, 8'd2);
    expect_seg(2, 1, 0, 1, 0, 0, 1);
    expect_seg(6, 0, 1, 1, 0, 0, 3);
    expect_seg(0, 1, 0, 0, 0, 0, 0);
    start_pulse();
    repeat (3) @(posedge clk);
    #7;
    reset_n = 1'b0;
    #1;
    chk("async_tone_en",  int'(bus.tone_en), 0);
    chk("async_gen_rst",  int'(bus.gen_rst), 1);
    chk("async_busy",     int'(bus.busy), 0);
    chk("async_note_sel", int'(bus.note_sel), 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    expect_seg(0, 1, 0, 1, 0, 0, 1);
    expect_seg(6, 0, 1, 1, 0, 0, 8);
    expect_seg(6, 1, 0, 1, 0, 0, 4);
    expect_seg(6, 1, 0, 1, 0, 1, 1);
    expect_seg(6, 1, 0, 0, 1, 1, 1);
    expect_seg(6, 1, 0, 0, 0, 1, 0);
    start_pulse();
    cyc(20);

    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
